// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the multicycle CPU's iterative mult/div unit.
// Accepts a start request, clears the selected unit, steps it for a fixed
// number of cycles, then pulses the Hi/Lo load with the mux selects latched
// to the op. A divide by zero is trapped before the divider ever runs.
// Optional feature macro: MULDIV_ABORT_EN adds an `abort` input that cancels
// an op still in CLEAR or RUN.
module muldiv_sequencer #(
   parameter int MULT_CYCLES = 32,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] divisor,
`ifdef MULDIV_ABORT_EN
   input  logic        abort,
`endif
   output logic        unit_clear,
   output logic        mult_run,
   output logic        div_run,
   output logic        busy,
   output logic        hilo_load,
   output logic        sel_mux_hi,
   output logic        sel_mux_lo,
   output logic        div_zero,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_WRITE,
      S_ZERR
   } state_t;

   // Counter reload values: RUN lasts exactly N cycles, ending when cnt == 0.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_t           state, state_nxt;
   logic             op_mult, op_mult_nxt;   // 1 = multiply in flight, 0 = divide
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sel, sel_nxt;           // Hi/Lo mux select, held between ops
   logic             abort_req;

`ifdef MULDIV_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // State, op, counter and select registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         op_mult <= 1'b0;
         cnt     <= '0;
         sel     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state   <= state_nxt;
         op_mult <= op_mult_nxt;
         cnt     <= cnt_nxt;
         sel     <= sel_nxt;
      end
   end

   // Next-state logic and Moore outputs decoded from the current state.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      op_mult_nxt = op_mult;
      cnt_nxt     = cnt;
      sel_nxt     = sel;
      unit_clear  = 1'b0;
      mult_run    = 1'b0;
      div_run     = 1'b0;
      busy        = 1'b0;
      hilo_load   = 1'b0;
      div_zero    = 1'b0;
      done        = 1'b0;

      case (state)
         S_IDLE: begin
            // Multiply wins a simultaneous request; the divide is dropped.
            if (!abort_req) begin
               if (start_mult) begin
                  op_mult_nxt = 1'b1;
                  state_nxt   = S_CLEAR;
               end else if (start_div) begin
                  op_mult_nxt = 1'b0;
                  state_nxt   = (divisor != 32'd0) ? S_CLEAR : S_ZERR;
               end
            end
         end
         S_CLEAR: begin
            unit_clear = 1'b1;
            busy       = 1'b1;
            cnt_nxt    = op_mult ? MULT_LOAD : DIV_LOAD;
            sel_nxt    = op_mult;
            state_nxt  = abort_req ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            mult_run = op_mult;
            div_run  = ~op_mult;
            if (abort_req) begin
               state_nxt = S_IDLE;
            end else if (cnt == '0) begin
               state_nxt = S_WRITE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_WRITE: begin
            hilo_load = 1'b1;
            done      = 1'b1;
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         S_ZERR: begin
            div_zero  = 1'b1;
            done      = 1'b1;
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign sel_mux_hi = sel;
   assign sel_mux_lo = sel;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed scenarios plus random start
// traffic, checked by a cycle-level reference model and a completion
// scoreboard. A second instance with tiny cycle counts covers the N = 1 edge.
module tb_muldiv_sequencer;

   localparam int MC = 32;
   localparam int DC = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] divisor;
`ifdef MULDIV_ABORT_EN
   logic        abort;
   logic        s_abort;
`endif
   logic unit_clear, mult_run, div_run, busy, hilo_load;
   logic sel_mux_hi, sel_mux_lo, div_zero, done;

   // Small instance: MULT_CYCLES = 1, DIV_CYCLES = 2.
   logic        s_start_mult, s_start_div;
   logic [31:0] s_divisor;
   logic s_unit_clear, s_mult_run, s_div_run, s_busy, s_hilo_load;
   logic s_sel_mux_hi, s_sel_mux_lo, s_div_zero, s_done;

   muldiv_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .divisor    (divisor),
`ifdef MULDIV_ABORT_EN
      .abort      (abort),
`endif
      .unit_clear (unit_clear),
      .mult_run   (mult_run),
      .div_run    (div_run),
      .busy       (busy),
      .hilo_load  (hilo_load),
      .sel_mux_hi (sel_mux_hi),
      .sel_mux_lo (sel_mux_lo),
      .div_zero   (div_zero),
      .done       (done)
   );

   muldiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(2), .CNT_W(1)) u_small (
      .clk        (clk),
      .reset      (reset),
      .start_mult (s_start_mult),
      .start_div  (s_start_div),
      .divisor    (s_divisor),
`ifdef MULDIV_ABORT_EN
      .abort      (s_abort),
`endif
      .unit_clear (s_unit_clear),
      .mult_run   (s_mult_run),
      .div_run    (s_div_run),
      .busy       (s_busy),
      .hilo_load  (s_hilo_load),
      .sel_mux_hi (s_sel_mux_hi),
      .sel_mux_lo (s_sel_mux_lo),
      .div_zero   (s_div_zero),
      .done       (s_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // One op in flight at most. An op accepted in cycle A with N run cycles
   // keeps busy high in cycles A+1 .. A+N+2; a zero divide only in A+1.
   typedef struct {
      int cyc;
      bit zerr;
      bit sel;
   } exp_t;

   exp_t sb_q[$];

   bit has_op    = 1'b0;
   int acc_cyc   = -100;
   int end_cyc   = -100;
   int op_n      = 0;
   bit op_zerr   = 1'b0;
   bit op_mult_m = 1'b0;
   bit sel_old   = 1'b0;
   bit sel_new   = 1'b0;

   function automatic bit exp_sel(input int c);
      if (has_op && !op_zerr && c >= acc_cyc + 2) return sel_new;
      return sel_old;
   endfunction

   task automatic model_reset();
      has_op  = 1'b0;
      end_cyc = -100;
      sel_old = 1'b0;
      sb_q.delete();
   endtask

   task automatic model_eval(input int c, input bit sm, input bit sd,
                             input logic [31:0] dv, input bit ab);
      bit in_flight;
      exp_t e;
      in_flight = has_op && !op_zerr && c > acc_cyc && c <= end_cyc && c <= acc_cyc + op_n + 1;
      if (ab && in_flight) begin
         end_cyc = c;
         if (sb_q.size() > 0) void'(sb_q.pop_back());
      end else if (reset && !ab && c > end_cyc && (sm || sd)) begin
         sel_old   = exp_sel(c);
         has_op    = 1'b1;
         acc_cyc   = c;
         op_mult_m = sm;
         op_zerr   = !sm && (dv == 32'd0);
         op_n      = sm ? MC : DC;
         sel_new   = sm;
         end_cyc   = op_zerr ? c + 1 : c + op_n + 2;
         e.cyc  = end_cyc;
         e.zerr = op_zerr;
         e.sel  = sm;
         sb_q.push_back(e);
      end
   endtask

   // ---------------- monitor ----------------
   // Per-cycle control-vector comparison plus completion scoreboard.
   always @(negedge clk) begin
      int c, d;
      bit act, run_ph;
      logic [8:0] exp_v, got_v;
      exp_t e;
      c      = cyc;
      d      = c - acc_cyc;
      act    = has_op && c > acc_cyc && c <= end_cyc;
      run_ph = act && !op_zerr && d >= 2 && d <= op_n + 1;
      exp_v  = {act,
                act && !op_zerr && d == 1,
                run_ph && op_mult_m,
                run_ph && !op_mult_m,
                act && !op_zerr && d == op_n + 2,
                act && op_zerr && d == 1,
                act && ((!op_zerr && d == op_n + 2) || (op_zerr && d == 1)),
                exp_sel(c), exp_sel(c)};
      got_v  = {busy, unit_clear, mult_run, div_run, hilo_load,
                div_zero, done, sel_mux_hi, sel_mux_lo};
      check("ctl_vector", 32'(got_v), 32'(exp_v));
      if (done === 1'b1) begin
         check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_done_cycle", c, e.cyc);
            check("sb_kind", {30'd0, hilo_load, div_zero}, e.zerr ? 32'd1 : 32'd2);
            if (!e.zerr) check("sb_sel", 32'(sel_mux_hi), 32'(e.sel));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit sm, input bit sd, input logic [31:0] dv, input bit ab);
      @(posedge clk);
      #1;
      start_mult = sm;
      start_div  = sd;
      divisor    = dv;
`ifdef MULDIV_ABORT_EN
      abort      = ab;
`endif
      model_eval(cyc, sm, sd, dv, ab);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         step(1'b0, 1'b0, 32'd0, 1'b0);
         if (cyc > end_cyc) break;
      end
   endtask

   // Runs one op on the small instance and returns the cycles from the
   // start cycle to the first matching completion pulse (-1 on timeout).
   task automatic small_op(input bit sm, input logic [31:0] dv, input bit want_zero,
                           output int lat);
      int c0;
      lat = -1;
      @(posedge clk);
      #1;
      s_start_mult = sm;
      s_start_div  = !sm;
      s_divisor    = dv;
      c0 = cyc;
      @(posedge clk);
      #1;
      s_start_mult = 1'b0;
      s_start_div  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if ((want_zero ? s_div_zero : s_hilo_load) === 1'b1) begin
            lat = cyc - c0;
            break;
         end
      end
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset        = 1'b0;
      start_mult   = 1'b0;
      start_div    = 1'b0;
      divisor      = 32'd0;
      s_start_mult = 1'b0;
      s_start_div  = 1'b0;
      s_divisor    = 32'd0;
`ifdef MULDIV_ABORT_EN
      abort        = 1'b0;
      s_abort      = 1'b0;
`endif
      model_reset();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {23'd0, busy, unit_clear, mult_run, div_run, hilo_load,
                              div_zero, done, sel_mux_hi, sel_mux_lo}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Multiply, divide, divide by zero.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      wait_idle();
      step(1'b0, 1'b1, 32'd7, 1'b0);
      wait_idle();
      step(1'b0, 1'b1, 32'd0, 1'b0);
      wait_idle();

      // Simultaneous requests, then a start_div while busy (cycle 10).
      step(1'b1, 1'b1, 32'd9, 1'b0);
      repeat (9) step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b1, 32'd5, 1'b0);
      wait_idle();

      // Back-to-back zero divides then a multiply held across the op.
      step(1'b0, 1'b1, 32'd0, 1'b0);
      step(1'b0, 1'b1, 32'd0, 1'b0);
      step(1'b0, 1'b1, 32'd0, 1'b0);
      for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 32'd0, 1'b0);
      wait_idle();

      // Reset at cycle 15 of a multiply, then a fresh divide by 3.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (14) step(1'b0, 1'b0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      check("reset_mid_op", {23'd0, busy, unit_clear, mult_run, div_run, hilo_load,
                             div_zero, done, sel_mux_hi, sel_mux_lo}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1'b0, 1'b1, 32'd3, 1'b0);
      wait_idle();

`ifdef MULDIV_ABORT_EN
      // Abort at cycle 20 of a multiply; abort in IDLE blocks a start.
      step(1'b1, 1'b0, 32'd0, 1'b0);
      repeat (19) step(1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      wait_idle();
      step(1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      wait_idle();
`endif

      // Random traffic: sparse, overlapping and held start requests.
      for (int i = 0; i < 3000; i++) begin
         bit sm, sd;
         logic [31:0] dv;
         sm = ($urandom_range(0, 9) == 0);
         sd = ($urandom_range(0, 7) == 0);
         dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         step(sm, sd, dv, 1'b0);
      end
      wait_idle();
      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
      check("sb_drained", sb_q.size(), 32'd0);

      // Boundary: one-cycle multiply, two-cycle divide, zero divide.
      small_op(1'b1, 32'd0, 1'b0, lat);
      check("small_mult_latency", lat, 32'd3);
      small_op(1'b0, 32'd5, 1'b0, lat);
      check("small_div_latency", lat, 32'd4);
      small_op(1'b0, 32'd0, 1'b1, lat);
      check("small_zero_latency", lat, 32'd1);
      check("small_idle_after", {31'd0, s_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
